// File: rtl/arr_stim_pkg.sv
// Shared types and helpers for the arr_stim stimulus generator.
// Holds the FSM state enum, the LFSR tap mask, the counter width and the LFSR step function.
package arr_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam int          CNT_W     = 16;

  // Galois step for x^32+x^22+x^2+x+1: shift right, fold the taps in when bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/arr_stim_lfsr.sv
// 32-bit Galois LFSR with synchronous load and advance; reset also loads the seed.
module arr_stim_lfsr
  import arr_stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (advance) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/arr_stim.sv
// Stimulus generator for the arr comparator: issues LFSR-derived sig0/sig1 vector pairs.
// Define ARR_STIM_INJECT_EN to corrupt one bit of sig1 every INJECT_PERIOD-th vector.
module arr_stim
  import arr_stim_pkg::*;
#(
  parameter int          LENGTH        = 1,
  parameter logic [31:0] SEED          = 32'h1,
  parameter int          INJECT_PERIOD = 16
) (
  input  logic              arr_stim_clk_ip,
  input  logic              arr_stim_rst_ip,
  input  logic              arr_stim_start_ip,
  input  logic              arr_stim_pause_ip,
  input  logic [CNT_W-1:0]  arr_stim_count_ip,
  output logic [LENGTH-1:0] arr_stim_sig0_op,
  output logic [LENGTH-1:0] arr_stim_sig1_op,
  output logic              arr_stim_valid_op,
  output logic              arr_stim_busy_op,
  output logic              arr_stim_done_op,
  output logic [CNT_W-1:0]  arr_stim_injected_op
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  index_q, index_d;
  logic [CNT_W-1:0]  injected_q, injected_d;
  logic [LENGTH-1:0] sig0_q, sig0_d;
  logic [LENGTH-1:0] sig1_q, sig1_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              lfsr_load;
  logic              lfsr_adv;
  logic [31:0]       lfsr_state;
  logic [LENGTH-1:0] rep_vec;
  logic [LENGTH-1:0] flip_vec;
  logic              corrupt;

  arr_stim_lfsr u_lfsr (
    .clk     (arr_stim_clk_ip),
    .rst_n   (arr_stim_rst_ip),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (SEED_EFF),
    .state   (lfsr_state)
  );

  // Wide vectors repeat the 32-bit state, so bit i always follows state bit i%32.
  for (genvar gi = 0; gi < LENGTH; gi++) begin : g_rep
    assign rep_vec[gi] = lfsr_state[gi % 32];
  end

  if (LENGTH < 32) begin : g_narrow
    logic lfsr_hi_unused;
    assign lfsr_hi_unused = ^lfsr_state[31:LENGTH];
  end

`ifdef ARR_STIM_INJECT_EN
  logic [CNT_W-1:0] bit_sel;
  assign corrupt = (index_q % CNT_W'(INJECT_PERIOD)) == CNT_W'(INJECT_PERIOD - 1);
  assign bit_sel = index_q % CNT_W'(LENGTH);
  for (genvar gi = 0; gi < LENGTH; gi++) begin : g_flip
    assign flip_vec[gi] = corrupt && (bit_sel == CNT_W'(gi));
  end
`else
  localparam int INJECT_PERIOD_UNUSED = INJECT_PERIOD;
  assign corrupt  = 1'b0;
  assign flip_vec = '0;
`endif

  // Outputs are one register stage behind the state, so busy rises with the first valid.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    injected_d  = injected_q;
    sig0_d      = sig0_q;
    sig1_d      = sig1_q;
    valid_d     = 1'b0;
    busy_d      = (state_q == ST_RUN);
    done_d      = (state_q == ST_DONE);
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arr_stim_start_ip) begin
          remaining_d = arr_stim_count_ip;
          index_d     = '0;
          injected_d  = '0;
          lfsr_load   = 1'b1;
          state_d     = (arr_stim_count_ip == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!arr_stim_pause_ip) begin
          valid_d     = 1'b1;
          lfsr_adv    = 1'b1;
          sig0_d      = rep_vec;
          sig1_d      = rep_vec ^ flip_vec;
          index_d     = index_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (corrupt && (injected_q != '1)) begin
            injected_d = injected_q + 1'b1;
          end
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge arr_stim_clk_ip) begin
    if (!arr_stim_rst_ip) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      index_q     <= '0;
      injected_q  <= '0;
      sig0_q      <= '0;
      sig1_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      injected_q  <= injected_d;
      sig0_q      <= sig0_d;
      sig1_q      <= sig1_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign arr_stim_sig0_op     = sig0_q;
  assign arr_stim_sig1_op     = sig1_q;
  assign arr_stim_valid_op    = valid_q;
  assign arr_stim_busy_op     = busy_q;
  assign arr_stim_done_op     = done_q;
  assign arr_stim_injected_op = injected_q;

endmodule

// File: tb/tb_arr_stim.sv
// Directed bench for arr_stim: an 8-bit and a 40-bit instance driven in lockstep from one stimulus.
// Corruption expectations follow ARR_STIM_INJECT_EN when it is defined for the build.
module tb_arr_stim;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        pause;
  logic [15:0] count_in;

  logic [7:0]  sig0_8, sig1_8;
  logic        valid8, busy8, done8;
  logic [15:0] inj8;
  logic [39:0] sig0_40, sig1_40;
  logic        valid40, busy40, done40;
  logic [15:0] inj40;

  int n_vec = 0;
  int n_err = 0;

  // LFSR states from SEED=1, stepped by hand.
  localparam logic [31:0] EXP_ST [8] = '{
    32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001,
    32'hB02C0003, 32'hD8360002, 32'h6C1B0001, 32'hB62D8003
  };

  always #5 clk = ~clk;

  arr_stim #(.LENGTH(8), .SEED(32'h1), .INJECT_PERIOD(10)) dut8 (
    .arr_stim_clk_ip      (clk),
    .arr_stim_rst_ip      (rst_n),
    .arr_stim_start_ip    (start),
    .arr_stim_pause_ip    (pause),
    .arr_stim_count_ip    (count_in),
    .arr_stim_sig0_op     (sig0_8),
    .arr_stim_sig1_op     (sig1_8),
    .arr_stim_valid_op    (valid8),
    .arr_stim_busy_op     (busy8),
    .arr_stim_done_op     (done8),
    .arr_stim_injected_op (inj8)
  );

  arr_stim #(.LENGTH(40), .SEED(32'h0), .INJECT_PERIOD(4)) dut40 (
    .arr_stim_clk_ip      (clk),
    .arr_stim_rst_ip      (rst_n),
    .arr_stim_start_ip    (start),
    .arr_stim_pause_ip    (pause),
    .arr_stim_count_ip    (count_in),
    .arr_stim_sig0_op     (sig0_40),
    .arr_stim_sig1_op     (sig1_40),
    .arr_stim_valid_op    (valid40),
    .arr_stim_busy_op     (busy40),
    .arr_stim_done_op     (done40),
    .arr_stim_injected_op (inj40)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sig0_8"}, sig0_8, 0);
    chk({tag, "_sig1_8"}, sig1_8, 0);
    chk({tag, "_sig0_40"}, sig0_40, 0);
    chk({tag, "_sig1_40"}, sig1_40, 0);
    chk({tag, "_valid"}, {valid8, valid40}, 0);
    chk({tag, "_busy"}, {busy8, busy40}, 0);
    chk({tag, "_done"}, {done8, done40}, 0);
    chk({tag, "_inj"}, {inj8, inj40}, 0);
  endtask

  task automatic run(input int cnt, input int pause_at, input int pause_len);
    int seen, paused, exp_inj8, exp_inj40;
    bit fin, was_pause, c8, c40;
    logic [31:0] st;
    logic [7:0]  e8, f8;
    logic [39:0] e40, f40;
    start    = 1'b1;
    count_in = 16'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_lags_start", {busy8, busy40}, 0);
    chk("inj_cleared", {inj8, inj40}, 0);
    seen = 0; paused = 0; exp_inj8 = 0; exp_inj40 = 0; fin = 1'b0;
    for (int cyc = 0; cyc < cnt + pause_len + 4 && !fin; cyc++) begin
      was_pause = (seen == pause_at) && (paused < pause_len);
      pause = was_pause;
      if (was_pause) paused++;
      @(posedge clk); #1;
      if (seen == cnt) begin
        chk("done_pulse", {done8, done40}, 2'b11);
        chk("busy_drop", {busy8, busy40}, 0);
        chk("valid_end", {valid8, valid40}, 0);
        chk("inj8_end", inj8, exp_inj8);
        chk("inj40_end", inj40, exp_inj40);
        fin = 1'b1;
      end else if (was_pause) begin
        st = EXP_ST[(seen > 0) ? seen - 1 : 0];
        chk("pause_valid", {valid8, valid40}, 0);
        chk("pause_busy", {busy8, busy40}, 2'b11);
        chk("pause_done", {done8, done40}, 0);
        if (seen > 0 && seen <= 8) chk("pause_hold8", sig0_8, st[7:0]);
      end else begin
        chk("valid", {valid8, valid40}, 2'b11);
        chk("busy", {busy8, busy40}, 2'b11);
        chk("no_early_done", {done8, done40}, 0);
`ifdef ARR_STIM_INJECT_EN
        c8  = (seen % 10) == 9;
        c40 = (seen % 4) == 3;
`else
        c8  = 1'b0;
        c40 = 1'b0;
`endif
        if (c8) exp_inj8++;
        if (c40) exp_inj40++;
        if (seen < 8) begin
          st  = EXP_ST[seen];
          e8  = st[7:0];
          e40 = {st[7:0], st};
          f8  = c8 ? (8'd1 << (seen % 8)) : 8'd0;
          f40 = c40 ? (40'd1 << (seen % 40)) : 40'd0;
          chk("sig0_8", sig0_8, e8);
          chk("sig1_8", sig1_8, e8 ^ f8);
          chk("sig0_40", sig0_40, e40);
          chk("sig1_40", sig1_40, e40 ^ f40);
        end
        chk("inj8_run", inj8, exp_inj8);
        chk("inj40_run", inj40, exp_inj40);
        seen++;
      end
    end
    pause = 1'b0;
    if (!fin) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", {done8, done40}, 0);
    chk("inj_hold", {inj8, inj40}, {16'(exp_inj8), 16'(exp_inj40)});
  endtask

  initial begin
    int seen;
    rst_n    = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    count_in = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, -1, 0);
    run(4, -1, 0);
    run(8, -1, 0);
    run(5, 2, 3);

    // Reset in the middle of a 10-vector run, right after vector index 1 is issued.
    start    = 1'b1;
    count_in = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    seen  = 0;
    for (int cyc = 0; cyc < 20 && seen < 2; cyc++) begin
      @(posedge clk); #1;
      if (valid8) seen++;
    end
    chk("rst_reach_vec2", seen, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs("midrun_rst");
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", {done8, done40, busy8, busy40}, 0);
    end
    run(3, -1, 0);

`ifdef ARR_STIM_INJECT_EN
    run(100, -1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/arr_stim.md
# arr_stim

Stimulus generator for the `arr` comparator array: the writer end of the sig0/sig1 equality-check interface. It produces pseudo-random LENGTH-bit vector pairs on every active cycle, optionally corrupting one bit of sig1 at a fixed period, and counts the mismatches it injected. The bench then cross-checks that count against the `EXM_ERROR` count raised by the paired `arr` instance. One instance sits beside each `arr` under `duv`, clocked from `sim_ctrl`'s clock output.

## Interface
- LENGTH, 1: vector width; legal range 1..255, matching the `arr` instance it drives.
- SEED, 32'h1: initial LFSR value. A value of 0 is replaced by 32'h1.
- INJECT_PERIOD, 16: when injection is compiled in, every INJECT_PERIOD-th vector is corrupted. Legal values are ≥ 2.
- arr_stim_clk_ip  input  1  clock.
- arr_stim_rst_ip  input  1  reset; synchronous, active-low.
- arr_stim_start_ip  input  1  single-cycle start pulse.
- arr_stim_pause_ip  input  1  stall; while high, no vector is issued.
- arr_stim_count_ip  input  16  number of vectors to issue; sampled on start.
- arr_stim_sig0_op  output  LENGTH  reference vector.
- arr_stim_sig1_op  output  LENGTH  compare vector, equal to sig0 unless corrupted.
- arr_stim_valid_op  output  1  high on cycles where a new vector is issued.
- arr_stim_busy_op  output  1  high in RUN.
- arr_stim_done_op  output  1  one-cycle pulse at the end of a run.
- arr_stim_injected_op  output  16  mismatches injected in the current or last run.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads the remaining-vector counter from count, reloads the LFSR from SEED, and clears the injected count and the vector index.
  - Next state is RUN, or DONE if count=0.
- RUN, pause=0:
  - Issue one vector: valid=1, advance the LFSR, increment the vector index, decrement the remaining counter.
  - When the remaining counter reaches 0 after an issue, go to DONE.
- RUN, pause=1: valid=0; sig0 and sig1 hold; no counter or LFSR change.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, tap mask 32'h80200003. It shifts right; when the LSB is 1, the mask is XORed in.
- sig0 = low LENGTH bits of the current LFSR state replicated ceil(LENGTH/32) times. Bits above 31 repeat the state.
- The vector index is 16 bits and wraps at 65535 → 0.
- Corruption:
  - Condition: index % INJECT_PERIOD == INJECT_PERIOD-1.
  - Action: sig1 = sig0 with bit (index % LENGTH) inverted, and injected increments.
  - injected saturates at 16'hFFFF.
- Non-corrupted vectors: sig1 = sig0.

## Timing
- Reset values: sig0=0, sig1=0, valid=0, busy=0, done=0, injected=0, state=IDLE, LFSR=SEED, index=0.
- Reset asserted mid-run: all outputs return to reset values on the next clock edge; no done pulse is produced.
- Start latency: start sampled at edge N → busy=1 and the first valid=1 at edge N+1 (pause low).
- All outputs are registered. A vector appears in the same cycle its valid is high and holds until the next issue.
- A count of C with no pauses gives valid high for C consecutive cycles. done pulses on the cycle after the last valid, and busy drops in the same cycle.
- count=0: done pulses at N+1; busy and valid are never asserted.
- pause high in the same cycle as the last remaining vector: the issue is deferred; DONE is reached only after that vector is issued.
- injected updates in the same cycle as the corrupted vector.
- injected holds its value through DONE and IDLE until the next start.

## Configuration
- ARR_STIM_INJECT_EN defined: corruption is active as described.
- ARR_STIM_INJECT_EN not defined:
  - sig1 always equals sig0 and injected stays 0.
  - The injection logic and INJECT_PERIOD usage are compiled out.

## Structure
- Shared package arr_stim_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the LFSR tap-mask constant 32'h80200003;
  - the counter width constant (16);
  - the next-state function for the LFSR.
- One sub-module, arr_stim_lfsr: a 32-bit Galois LFSR with load, seed and advance ports. Replication and corruption stay in arr_stim.

## Test plan
- Reset, then start with count=0 → done at N+1, valid never high, injected=0.
- LENGTH=8, SEED=1, count=4, no pause, INJECT_EN off → 4 consecutive valids, sig0 sequence matching the reference LFSR model, sig1==sig0, done one cycle after the last valid.
- LENGTH=40, INJECT_EN on, INJECT_PERIOD=4, count=8 → vectors 3 and 7 corrupted at bits 3 and 7, injected=2, sig0[39:32]==sig0[7:0].
- Pause held 3 cycles mid-run with count=5 → 5 valids total, outputs frozen during the pause, done after the fifth valid.
- Reset driven low while busy at vector 2 of 10 → all outputs 0 at the next edge, no done pulse; a fresh start replays from SEED.
- Paired with `arr` of equal LENGTH, INJECT_EN on, count=100, INJECT_PERIOD=10 → injected=10, equal to `arr`'s error count.
